// File: rtl/yutorina_gpr_wb_pkg.sv
// Shared GPR types and writeback-controller constants (late-queue depth, pointer width).
// Imported by yutorina_wb_fifo and yutorina_gpr_wb.
package yutorina_gpr_wb_pkg;

    localparam int GPR_NUM     = 32;
    localparam int GPR_ADDR_W  = 5;
    localparam int WORD_DATA_W = 32;

    typedef logic [GPR_ADDR_W-1:0]  GprAddrBus;
    typedef logic [WORD_DATA_W-1:0] WordDataBus;

    localparam GprAddrBus GPR_ZERO = '0;

    localparam int LQ_DEPTH_DEF = 2;

    typedef struct packed {
        GprAddrBus  addr;
        WordDataBus data;
    } lq_entry_t;

    // Source selected for the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_LATE = 2'd2
    } wb_src_e;

    function automatic int lq_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/yutorina_wb_fifo.sv
// Late-result queue: synchronous FIFO of {addr, data} with full/empty flags and
// a combinational head; storage is not reset, only pointers and count are.
module yutorina_wb_fifo
    import yutorina_gpr_wb_pkg::*;
#(
    parameter int DEPTH = LQ_DEPTH_DEF,
    parameter int PTR_W = lq_ptr_w(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  lq_entry_t i_din,
    input  logic      i_pop,
    output lq_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    lq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/yutorina_gpr_wb.sv
// GPR writeback controller: sole owner of the register-file write port, merging pipeline
// and late results with a pending-destination scoreboard. Optional checks: YUTORINA_WB_ASSERT_EN.
module yutorina_gpr_wb
    import yutorina_gpr_wb_pkg::*;
#(
    parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pipe_we_,
    input  GprAddrBus  pipe_addr,
    input  WordDataBus pipe_data,
    input  logic       late_issue,
    input  GprAddrBus  late_issue_addr,
    input  logic       late_valid,
    input  GprAddrBus  late_addr,
    input  WordDataBus late_data,
    output logic       late_ready,
    input  GprAddrBus  chk_addr1,
    input  GprAddrBus  chk_addr2,
    input  GprAddrBus  chk_dst,
    output logic       busy,
    output logic       gpr_we_,
    output GprAddrBus  gpr_w_addr,
    output WordDataBus gpr_w_data
);

    if (LQ_DEPTH < 2 || (LQ_DEPTH & (LQ_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("yutorina_gpr_wb: LQ_DEPTH must be a power of two >= 2");
    end

    logic [GPR_NUM-1:0] r_sb;
    logic [GPR_NUM-1:0] w_sb_nxt;
    logic               r_we_;
    GprAddrBus          r_addr;
    WordDataBus         r_data;

    lq_entry_t w_lq_head;
    lq_entry_t w_lq_din;
    logic      w_lq_full;
    logic      w_lq_empty;
    logic      w_late_acc;
    logic      w_push;
    logic      w_pop;
    logic      w_pipe_wr;
    wb_src_e   w_src;

    assign late_ready = ~w_lq_full;
    assign w_late_acc = late_valid & late_ready;
    // r0 late results complete the handshake but never occupy a queue slot.
    assign w_push     = w_late_acc & (late_addr != GPR_ZERO);
    assign w_lq_din   = '{addr: late_addr, data: late_data};
    assign w_pipe_wr  = ~pipe_we_ & (pipe_addr != GPR_ZERO);
    assign w_pop      = (w_src == SRC_LATE);

    yutorina_wb_fifo #(
        .DEPTH (LQ_DEPTH),
        .PTR_W (lq_ptr_w(LQ_DEPTH))
    ) u_lq (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_lq_din),
        .i_pop   (w_pop),
        .o_head  (w_lq_head),
        .o_full  (w_lq_full),
        .o_empty (w_lq_empty)
    );

    always_comb begin
        w_src = SRC_NONE;
        if (w_pipe_wr) begin
            w_src = SRC_PIPE;
        end else if (!w_lq_empty) begin
            w_src = SRC_LATE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we_  <= 1'b1;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            case (w_src)
                SRC_PIPE: begin
                    r_we_  <= 1'b0;
                    r_addr <= pipe_addr;
                    r_data <= pipe_data;
                end
                SRC_LATE: begin
                    r_we_  <= 1'b0;
                    r_addr <= w_lq_head.addr;
                    r_data <= w_lq_head.data;
                end
                default: r_we_ <= 1'b1;
            endcase
        end
    end

    // Clear is applied before set so an issue to the register being released wins.
    always_comb begin
        w_sb_nxt = r_sb;
        if (w_pop) w_sb_nxt[w_lq_head.addr] = 1'b0;
        if (late_issue && (late_issue_addr != GPR_ZERO)) w_sb_nxt[late_issue_addr] = 1'b1;
        w_sb_nxt[GPR_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sb <= '0;
        else      r_sb <= w_sb_nxt;
    end

    assign busy       = r_sb[chk_addr1] | r_sb[chk_addr2] | r_sb[chk_dst];
    assign gpr_we_    = r_we_;
    assign gpr_w_addr = r_addr;
    assign gpr_w_data = r_data;

`ifdef YUTORINA_WB_ASSERT_EN
    logic       r_chk_hold;
    GprAddrBus  r_chk_addr;
    WordDataBus r_chk_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_chk_hold <= 1'b0;
        else      r_chk_hold <= late_valid & ~late_ready;
    end

    always_ff @(posedge clk) begin
        r_chk_addr <= late_addr;
        r_chk_data <= late_data;
    end

    always @(posedge clk) begin
        if (rst) begin
            if (w_pipe_wr && r_sb[pipe_addr])
                $error("[%0t] gpr_wb: WAW pipeline write to pending r%0d", $time, pipe_addr);
            if (w_push && !r_sb[late_addr])
                $error("[%0t] gpr_wb: late result to non-pending r%0d", $time, late_addr);
            if (late_issue && (late_issue_addr != GPR_ZERO) && r_sb[late_issue_addr])
                $error("[%0t] gpr_wb: late issue to already pending r%0d", $time, late_issue_addr);
            if (r_chk_hold && late_valid && ((late_addr != r_chk_addr) || (late_data != r_chk_data)))
                $error("[%0t] gpr_wb: late result changed while stalled, r%0d", $time, late_addr);
        end
    end
`endif

endmodule

// File: tb/tb_yutorina_gpr_wb.sv
// Testbench for yutorina_gpr_wb: vector table plus hand sequences, with a write-port
// scoreboard queue and a small queue/scoreboard reference model.
module tb_yutorina_gpr_wb;
    import yutorina_gpr_wb_pkg::*;

    localparam int LQD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pipe_we_;
    GprAddrBus  pipe_addr;
    WordDataBus pipe_data;
    logic       late_issue;
    GprAddrBus  late_issue_addr;
    logic       late_valid;
    GprAddrBus  late_addr;
    WordDataBus late_data;
    logic       late_ready;
    GprAddrBus  chk_addr1;
    GprAddrBus  chk_addr2;
    GprAddrBus  chk_dst;
    logic       busy;
    logic       gpr_we_;
    GprAddrBus  gpr_w_addr;
    WordDataBus gpr_w_data;

    always #5 clk = ~clk;

    yutorina_gpr_wb #(.LQ_DEPTH(LQD)) dut (
        .clk             (clk),
        .rst             (rst),
        .pipe_we_        (pipe_we_),
        .pipe_addr       (pipe_addr),
        .pipe_data       (pipe_data),
        .late_issue      (late_issue),
        .late_issue_addr (late_issue_addr),
        .late_valid      (late_valid),
        .late_addr       (late_addr),
        .late_data       (late_data),
        .late_ready      (late_ready),
        .chk_addr1       (chk_addr1),
        .chk_addr2       (chk_addr2),
        .chk_dst         (chk_dst),
        .busy            (busy),
        .gpr_we_         (gpr_we_),
        .gpr_w_addr      (gpr_w_addr),
        .gpr_w_data      (gpr_w_data)
    );

    typedef struct { logic [4:0] addr; logic [31:0] data; int due; } exp_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;
    typedef struct {
        logic pwe; logic [4:0] pa; logic [31:0] pd;
        logic li;  logic [4:0] lia;
        logic lv;  logic [4:0] la; logic [31:0] ld;
        logic [4:0] c1;
        logic e_we; logic [4:0] e_a; logic [31:0] e_d; logic e_busy; logic e_rdy;
    } vec_t;

    exp_t        exp_q[$];
    ent_t        mq[$];
    logic [31:0] msb;
    int          cyc;
    int          total;
    int          bad;
    vec_t        vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic idle_in();
        pipe_we_ = 1'b1; pipe_addr = '0; pipe_data = '0;
        late_issue = 1'b0; late_issue_addr = '0;
        late_valid = 1'b0; late_addr = '0; late_data = '0;
    endtask

    task automatic set_chk(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d);
        chk_addr1 = a1; chk_addr2 = a2; chk_dst = d;
    endtask

    task automatic model_reset();
        exp_q.delete();
        mq.delete();
        msb = '0;
    endtask

    // Called at the falling edge: compare against the model, then advance it for the coming edge.
    task automatic neg_work();
        exp_t e;
        ent_t le;
        logic pw;
        logic acc;
        chk("late_ready", 32'(late_ready), 32'(mq.size() < LQD));
        chk("busy", 32'(busy), 32'(msb[chk_addr1] | msb[chk_addr2] | msb[chk_dst]));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("wr_we_", 32'(gpr_we_), 32'd0);
            chk("wr_addr", 32'(gpr_w_addr), 32'(e.addr));
            chk("wr_data", gpr_w_data, e.data);
        end else begin
            chk("idle_we_", 32'(gpr_we_), 32'd1);
        end
        pw  = !pipe_we_ && (pipe_addr != 5'd0);
        acc = late_valid && (mq.size() < LQD);
        if (pw) begin
            exp_q.push_back('{pipe_addr, pipe_data, cyc + 1});
        end else if (mq.size() > 0) begin
            le = mq.pop_front();
            exp_q.push_back('{le.addr, le.data, cyc + 1});
            msb[le.addr] = 1'b0;
        end
        if (late_issue && late_issue_addr != 5'd0) msb[late_issue_addr] = 1'b1;
        if (acc && late_addr != 5'd0) mq.push_back('{late_addr, late_data});
    endtask

    task automatic cycle();
        @(negedge clk);
        neg_work();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        model_reset();
        //          pwe   pa     pd            li    lia    lv    la     ld             c1     e_we  e_a    e_d            e_busy e_rdy
        vt[0] = '{1'b0, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0000_0000, 5'd7, 1'b1, 5'd0, 32'h0000_0000, 1'b0, 1'b1};
        vt[1] = '{1'b1, 5'd0, 32'h0000_0000, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0000_0000, 5'd7, 1'b0, 5'd5, 32'h0000_1234, 1'b0, 1'b1};
        vt[2] = '{1'b1, 5'd0, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0000_0000, 5'd7, 1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b1};
        vt[3] = '{1'b1, 5'd0, 32'h0000_0000, 1'b0, 5'd0, 1'b1, 5'd7, 32'h0000_CAFE, 5'd7, 1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b1};
        vt[4] = '{1'b1, 5'd0, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0000_0000, 5'd7, 1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b1};
        vt[5] = '{1'b1, 5'd0, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0000_0000, 5'd7, 1'b0, 5'd7, 32'h0000_CAFE, 1'b0, 1'b1};
        vt[6] = '{1'b0, 5'd0, 32'h0000_DEAD, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0000_0000, 5'd0, 1'b1, 5'd7, 32'h0000_CAFE, 1'b0, 1'b1};
        vt[7] = '{1'b1, 5'd0, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0000_0000, 5'd0, 1'b1, 5'd7, 32'h0000_CAFE, 1'b0, 1'b1};

        // Reset held with random inputs.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pipe_we_ = 1'($urandom); pipe_addr = 5'($urandom); pipe_data = $urandom;
            late_issue = 1'($urandom); late_issue_addr = 5'($urandom);
            late_valid = 1'($urandom); late_addr = 5'($urandom); late_data = $urandom;
            set_chk(5'($urandom), 5'($urandom), 5'($urandom));
            @(negedge clk);
            chk("rst_we_", 32'(gpr_we_), 32'd1);
            chk("rst_ready", 32'(late_ready), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end
        idle_in();
        set_chk(5'd0, 5'd0, 5'd0);
        rst = 1'b1;

        // Vector table: basic pipe write, scoreboard, late latency, r0 handling.
        for (int i = 0; i < 8; i++) begin
            pipe_we_ = vt[i].pwe; pipe_addr = vt[i].pa; pipe_data = vt[i].pd;
            late_issue = vt[i].li; late_issue_addr = vt[i].lia;
            late_valid = vt[i].lv; late_addr = vt[i].la; late_data = vt[i].ld;
            set_chk(vt[i].c1, 5'd0, 5'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_we_", i), 32'(gpr_we_), 32'(vt[i].e_we));
            chk($sformatf("vec%0d_addr", i), 32'(gpr_w_addr), 32'(vt[i].e_a));
            chk($sformatf("vec%0d_data", i), gpr_w_data, vt[i].e_d);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            chk($sformatf("vec%0d_ready", i), 32'(late_ready), 32'(vt[i].e_rdy));
            neg_work();
            @(posedge clk);
            #1;
            cyc++;
        end

        // Contention: 6-cycle pipe burst while late r3, r4 arrive and a third is refused.
        idle_in();
        late_issue = 1'b1; late_issue_addr = 5'd3; cycle();
        late_issue_addr = 5'd4; cycle();
        idle_in();
        set_chk(5'd3, 5'd4, 5'd0);
        for (int i = 0; i < 6; i++) begin
            pipe_we_ = 1'b0; pipe_addr = 5'(10 + i); pipe_data = 32'hA000 + 32'(i);
            late_valid = (i < 3);
            late_addr = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : 5'd5;
            late_data = 32'hB000 + 32'(late_addr);
            @(negedge clk);
            if (i >= 2) chk($sformatf("burst%0d_ready_low", i), 32'(late_ready), 32'd0);
            neg_work();
            @(posedge clk);
            #1;
            cyc++;
        end
        idle_in();
        cycle();
        @(negedge clk);
        chk("burst_first_late_addr", 32'(gpr_w_addr), 32'd3);
        neg_work();
        @(posedge clk); #1; cyc++;
        @(negedge clk);
        chk("burst_second_late_addr", 32'(gpr_w_addr), 32'd4);
        neg_work();
        @(posedge clk); #1; cyc++;
        cycle();

        // Pipe write to r0 lets a queued entry drain; late result to r0 is swallowed.
        set_chk(5'd20, 5'd0, 5'd0);
        late_issue = 1'b1; late_issue_addr = 5'd20; cycle();
        idle_in();
        pipe_we_ = 1'b0; pipe_addr = 5'd1; pipe_data = 32'h1;
        late_valid = 1'b1; late_addr = 5'd20; late_data = 32'hD020; cycle();
        idle_in();
        pipe_we_ = 1'b0; pipe_addr = 5'd1; pipe_data = 32'h2; cycle();
        pipe_we_ = 1'b0; pipe_addr = 5'd0; pipe_data = 32'hFFFF; cycle();
        idle_in();
        @(negedge clk);
        chk("r0_drain_we_", 32'(gpr_we_), 32'd0);
        chk("r0_drain_addr", 32'(gpr_w_addr), 32'd20);
        neg_work();
        @(posedge clk); #1; cyc++;
        late_valid = 1'b1; late_addr = 5'd0; late_data = 32'hBAD0; cycle();
        idle_in();
        cycle();
        cycle();

        // Reset pulsed with two entries queued.
        set_chk(5'd21, 5'd22, 5'd0);
        late_issue = 1'b1; late_issue_addr = 5'd21; cycle();
        late_issue_addr = 5'd22; cycle();
        idle_in();
        pipe_we_ = 1'b0; pipe_addr = 5'd1; pipe_data = 32'h11;
        late_valid = 1'b1; late_addr = 5'd21; late_data = 32'hD021; cycle();
        pipe_addr = 5'd2; pipe_data = 32'h12; late_addr = 5'd22; late_data = 32'hD022; cycle();
        late_valid = 1'b0;
        pipe_addr = 5'd3; pipe_data = 32'h13;
        @(negedge clk);
        chk("pre_rst_ready", 32'(late_ready), 32'd0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        neg_work();
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(late_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_we_", 32'(gpr_we_), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        idle_in();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/yutorina_gpr_wb.md
# yutorina_gpr_wb

GPR writeback controller: the single owner of the register file's write port. Merges in-order pipeline results with out-of-order long-latency results (mul/div, uncached loads) through a small late-result queue, and keeps a 32-bit scoreboard of pending destinations. Decode uses the scoreboard to stall. Sits between the MEM/WB pipeline register, the long-latency units and `yutorina_gpr`.

## Interface
- `LQ_DEPTH`, default 2: late-result queue entries, power of two, ≥ 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-low (`RESET_EDGE` / `RESET_ENABLE`).
- `pipe_we_`  in  1  pipeline write request, active-low; no back-pressure.
- `pipe_addr`  in  `GprAddrBus`  pipeline destination.
- `pipe_data`  in  `WordDataBus`  pipeline result.
- `late_issue`  in  1  long-latency op issued this cycle; active-high.
- `late_issue_addr`  in  `GprAddrBus`  its destination.
- `late_valid`  in  1  late result offered.
- `late_addr`  in  `GprAddrBus`  late result destination.
- `late_data`  in  `WordDataBus`  late result data.
- `late_ready`  out  1  queue can accept; transfer happens when `late_valid & late_ready`.
- `chk_addr1`, `chk_addr2`, `chk_dst`  in  `GprAddrBus`  decode sources and destination.
- `busy`  out  1  any `chk_*` register is pending.
- `gpr_we_`  out  1  to GPR `we_`, active-low, registered.
- `gpr_w_addr`  out  `GprAddrBus`  to GPR `w_addr`, registered.
- `gpr_w_data`  out  `WordDataBus`  to GPR `w_data`, registered.

## Operation
- Scoreboard `sb[31:0]`:
  - Set `sb[late_issue_addr]` on `late_issue` when the address ≠ `GPR_ZERO`.
  - Clear `sb[r]` on the edge that loads a queued late result for r into the output register.
  - A set and a clear of the same bit in the same cycle: set wins.
  - `sb[0]` is constant 0.
- `busy = sb[chk_addr1] | sb[chk_addr2] | sb[chk_dst]`; combinational from registered `sb` only.
- Late queue: FIFO of {addr, data}, `LQ_DEPTH` entries.
  - `late_ready = !full`, taken from registered state only. When full, it stays 0 even in a cycle that pops.
- Per-cycle arbitration into the output register:
  1. If `pipe_we_` = 0 and `pipe_addr` ≠ 0: write the pipeline result.
  2. Else, if the queue is non-empty: pop the head and write it.
  3. Else: `gpr_we_` = 1. Address and data hold their previous values.
- A pipeline write to r0 is dropped and frees the port for the queue in that cycle.
- A late result addressed to r0 is accepted and discarded; it is never enqueued.
- Push and pop in the same cycle are legal at any occupancy below full.

## Timing
- Reset values:
  - `gpr_we_` = 1, `gpr_w_addr` = 0, `gpr_w_data` = 0.
  - `sb` = 0, queue empty.
  - `late_ready` = 1, `busy` = 0.
- Reset asserted mid-operation discards the queue and the scoreboard immediately.
- Pipeline path latency: 1 cycle (request at edge N → on the GPR port after edge N+1).
- Late path latency:
  - Minimum 2 cycles: accepted at N, enqueued N+1, on the port after N+2.
  - Add one cycle per cycle of pipeline contention.
- `busy` falls in the same cycle `gpr_we_` = 0 for the released register. The GPR's same-cycle read bypass then delivers the data, so no extra forwarding is needed.
- A `late_issue` is reflected in `busy` from the next cycle.

## Configuration
- `YUTORINA_WB_ASSERT_EN` defined: simulation checks, each reporting `$error` with time and address, on:
  - a pipeline write to a register with `sb` set (WAW);
  - a late result whose `sb` bit is clear;
  - a `late_issue` to an already-pending register;
  - `late_valid` held but address or data changed while `late_ready` = 0.
- Not defined: no checking logic, identical functional behaviour.

## Structure
- Shared header `gpr.h`: `GprAddrBus`, `WordDataBus`, `GPR_NUM`, `GPR_ZERO`.
- New header `gpr_wb.h`: default `LQ_DEPTH` and queue pointer width.
- Sub-module `yutorina_wb_fifo`:
  - synchronous FIFO with full/empty flags, push/pop, head data;
  - same clock and reset as the parent.

## Test plan
- Reset: hold `rst` = 0 with random inputs → `gpr_we_` = 1, `late_ready` = 1, `busy` = 0. After release, pipe write r5 = 32'h1234 → port shows we_ = 0, addr 5, data 32'h1234 one cycle later.
- Scoreboard:
  - `late_issue` r7 → `busy` = 1 for `chk_addr1` = 7 from the next cycle.
  - Late result r7 = 32'hCAFE on an idle pipe → written 2 cycles after acceptance.
  - `busy` = 0 in the write cycle itself.
- Contention: pipe writes every cycle for 6 cycles while late results r3 and r4 arrive →
  - `late_ready` drops after 2 accepts;
  - both late writes follow the pipe burst in order r3, r4.
- r0 handling:
  - pipe write to r0 → no port write, and a queued entry drains that cycle;
  - `late_issue` r0 → `busy` stays 0.
- Reset mid-queue: 2 entries queued, reset pulsed → queue empty, `sb` = 0, no stale write after release.
- With `YUTORINA_WB_ASSERT_EN`: pipe write to pending r9 → exactly one `$error`.
